// File: rtl/branch_resolve_stage.sv
// branch_resolve_stage
//   Execute-stage branch resolution. Consumes the NZCV flags of the
//   rs1 - rs2 subtraction and evaluates the RV32I/RV64I branch condition.
//   It computes the target and fall-through PCs and flags mispredictions,
//   then registers the outcome into a one-entry valid/ready pipeline
//   register with flush.
//
// Parameters
//   XLEN            datapath / PC width
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake (in_ready = !out_valid | out_ready)
//   in_is_branch    1 = conditional branch, 0 = pass-through
//   in_funct3       branch funct3
//   in_n/z/c/v      adder flags from the subtraction
//   in_pc, in_imm   branch PC and sign-extended B-immediate
//   in_pred_taken   fetch-stage prediction
//   flush           kills the held entry and any same-cycle load
//   out_valid/ready downstream handshake
//   out_taken       resolved direction
//   out_target      in_pc + in_imm
//   out_illegal     funct3 010/011 on a branch
//   out_misaligned  taken with target[1:0] != 0
//   redirect_valid  one-cycle mispredict pulse, the cycle after load
//   redirect_pc     correct next PC
//
// Optional build macro
//   BRANCH_STATS_EN adds 32-bit counters stat_branches, stat_taken and
//                   stat_mispredict for legal, non-flushed branch loads.

module branch_resolve_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_branch,
    input  logic [2:0]      in_funct3,
    input  logic            in_n,
    input  logic            in_z,
    input  logic            in_c,
    input  logic            in_v,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic            out_misaligned,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispredict
`endif
);

    logic            valid_q, valid_d;
    logic            taken_q;
    logic            illegal_q;
    logic            misaligned_q;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] target_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            cond_true;
    logic            f3_illegal;
    logic            taken;
    logic            illegal;
    logic            misaligned;
    logic            mispredict;
    logic            load;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;

    // Flags come from rs1 - rs2: c=1 means no borrow, so rs1 >=u rs2.
    always_comb begin
        cond_true  = 1'b0;
        f3_illegal = 1'b0;
        unique case (in_funct3)
            3'b000:         cond_true  = in_z;
            3'b001:         cond_true  = ~in_z;
            3'b100:         cond_true  = in_n ^ in_v;
            3'b101:         cond_true  = ~(in_n ^ in_v);
            3'b110:         cond_true  = ~in_c;
            3'b111:         cond_true  = in_c;
            3'b010, 3'b011: f3_illegal = 1'b1;
            default:        cond_true  = 1'b0;
        endcase
    end

    assign taken       = in_is_branch & cond_true;
    assign illegal     = in_is_branch & f3_illegal;
    assign target      = in_pc + in_imm;
    assign fallthrough = in_pc + XLEN'(4);
    assign misaligned  = taken & (target[1:0] != 2'b00);
    // A misaligned target traps downstream, so it never redirects fetch.
    assign mispredict  = in_is_branch & ~illegal & ~misaligned
                       & (taken != in_pred_taken);

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (load)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
    end

    // Only a fresh load can raise the pulse, so a stalled entry never repeats it.
    assign redirect_valid_d = load & mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            taken_q          <= 1'b0;
            illegal_q        <= 1'b0;
            misaligned_q     <= 1'b0;
            target_q         <= '0;
            redirect_pc_q    <= '0;
        end else begin
            valid_q          <= valid_d;
            redirect_valid_q <= redirect_valid_d;
            if (load) begin
                taken_q       <= taken;
                illegal_q     <= illegal;
                misaligned_q  <= misaligned;
                target_q      <= target;
                redirect_pc_q <= taken ? target : fallthrough;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_taken      = taken_q;
    assign out_illegal    = illegal_q;
    assign out_misaligned = misaligned_q;
    assign out_target     = target_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic        stat_load;
    logic [31:0] stat_branches_q, stat_taken_q, stat_mispredict_q;

    assign stat_load = load & in_is_branch & ~illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q   <= '0;
            stat_taken_q      <= '0;
            stat_mispredict_q <= '0;
        end else if (stat_load) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (taken)
                stat_taken_q <= stat_taken_q + 32'd1;
            if (mispredict)
                stat_mispredict_q <= stat_mispredict_q + 32'd1;
        end
    end

    assign stat_branches   = stat_branches_q;
    assign stat_taken      = stat_taken_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
- Execute-stage consumer of the NZCV adder's subtract result (control=1, a=rs1, b=rs2).
- Evaluates the RV32I/RV64I branch condition from the flags, computes the target and fall-through PCs, and detects mispredictions.
- Registers the outcome into a one-entry pipeline register with valid/ready handshake and flush.
- Feeds the EX/MEM boundary and the fetch redirect path.

Parameters:
- XLEN, `XLEN, datapath and PC width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry
- in_is_branch  input  1  entry is a conditional branch; 0 = pass-through, no evaluation
- in_funct3  input  3  branch funct3
- in_n, in_z, in_c, in_v  input  1 each  flags from the adder (subtraction)
- in_pc  input  XLEN  branch PC
- in_imm  input  XLEN  sign-extended B-immediate
- in_pred_taken  input  1  fetch prediction
- flush  input  1  kill held and incoming entry
- out_valid  output  1  registered entry valid
- out_ready  input  1  downstream accepts
- out_taken  output  1  resolved direction
- out_target  output  XLEN  in_pc+in_imm
- out_illegal  output  1  funct3 is 010 or 011 with in_is_branch=1
- out_misaligned  output  1  taken and target[1:0]!=0
- redirect_valid  output  1  one-cycle mispredict pulse
- redirect_pc  output  XLEN  correct next PC

Behaviour:
- Reset (async, rst_n=0): all outputs 0.
  - This includes out_valid, redirect_valid, out_taken, out_illegal, out_misaligned, out_target and redirect_pc.
  - Reset mid-stall drops the held entry.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Load on the clk edge when in_valid & in_ready & !flush.
  - Latency 1 cycle.
  - Held entry is stable while out_valid & !out_ready.
- Condition (in_is_branch=1):
  - BEQ 000 -> z
  - BNE 001 -> !z
  - BLT 100 -> n^v
  - BGE 101 -> !(n^v)
  - BLTU 110 -> !c
  - BGEU 111 -> c
  - 010/011 -> taken=0, illegal=1.
- in_is_branch=0: taken=0, illegal=0, no redirect, target still registered.
- Arithmetic:
  - target = in_pc+in_imm, fallthrough = in_pc+4, both modulo 2^XLEN (wrap, no flag).
  - redirect_pc = taken ? target : fallthrough.
- Misaligned: set only when taken; takes priority over redirect.
  - redirect_valid=0; trap handled downstream.
- Redirect:
  - mispredict = in_is_branch & !illegal & !misaligned & (taken != in_pred_taken).
  - redirect_valid pulses exactly one cycle, the cycle after load.
  - It is not re-asserted while the entry is stalled.
- Flush:
  - out_valid=0 next edge.
  - Any same-cycle load is suppressed; flush wins over accept.
  - No redirect is generated for a flushed entry.
  - A pending redirect pulse (loaded same edge) is not produced.
- Simultaneous out_ready & in_valid with out_valid=1: old entry leaves and new entry loads on the same edge (full throughput, no bubble).

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_branches, stat_taken, stat_mispredict, each 32 bits.
  - Counters increment on each non-flushed load with in_is_branch=1 and legal funct3 (taken/mispredict as applicable).
  - Wrap at 2^32.
  - Async reset to 0.
  - Flush does not decrement.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- BLT, flags n=1,v=0, pc=0x100, imm=0x20, pred=0 -> next cycle out_valid=1, taken=1, target=0x120, redirect_valid=1 for one cycle, redirect_pc=0x120.
- BGEU c=0, pc=0x200, pred=1 -> taken=0, redirect_pc=0x204, redirect_valid=1; same with pred=0 -> redirect_valid=0.
- funct3=011 with in_is_branch=1 -> out_illegal=1, taken=0, no redirect; BEQ z=1, imm=0x6 -> out_misaligned=1, redirect_valid=0.
- Back-to-back entries with out_ready held 0 for 3 cycles -> in_ready=0, outputs stable, single redirect pulse; on release the next entry loads the same edge.
- flush asserted in the cycle of an in_valid mispredicting BNE -> out_valid stays 0, no redirect; rst_n low mid-stall -> all outputs 0 immediately.
- With BRANCH_STATS_EN: 5 legal branches, 3 taken, 2 mispredicted, 1 flushed -> counters 4/x/x consistent.
  - One-entry wrap: preload stat_branches near 0xFFFFFFFF via repeated loads -> wraps to 0.
  - pc=0xFFFFFFFC, XLEN=32, not taken -> redirect_pc=0x00000000.
